// File: rtl/hit_edge_collector_if.sv
// Bundle between the object bitmaps and the hit-edge collector: frame and
// draw-request inputs, plus the registered per-frame report outputs.
interface hit_edge_collector_if #(
  parameter int unsigned COUNT_WIDTH = 11
) ();
  logic                   startOfFrame;
  logic                   enable;
  logic                   objDrawingRequest;
  logic [2:0]             objHitEdgeCode;
  logic                   otherDrawingRequest;
  logic                   collision;
  logic [4:0]             edgeMask;
  logic [2:0]             firstEdgeCode;
  logic [COUNT_WIDTH-1:0] overlapCount;
  logic                   frameValid;

  // Drives the pixel-stream inputs and consumes the report.
  modport master (
    output startOfFrame, enable, objDrawingRequest, objHitEdgeCode, otherDrawingRequest,
    input  collision, edgeMask, firstEdgeCode, overlapCount, frameValid
  );

  // The collector itself.
  modport slave (
    input  startOfFrame, enable, objDrawingRequest, objHitEdgeCode, otherDrawingRequest,
    output collision, edgeMask, firstEdgeCode, overlapCount, frameValid
  );
endinterface

// File: rtl/hit_edge_collector.sv
// Per-frame collision collector: accumulates overlaps between an object's
// draw request and another object's, and publishes a registered report at
// each start-of-frame.
module hit_edge_collector #(
  parameter int unsigned COUNT_WIDTH = 11,
  parameter int unsigned MIN_PIXELS  = 1
) (
  input logic                clk,
  input logic                reset,
  hit_edge_collector_if.slave bus
);

  typedef enum logic [0:0] {StWaitSof, StCollect} state_e;

  state_e                 state_q, state_d;
  logic [4:0]             acc_mask_q, acc_mask_d;
  logic [2:0]             acc_first_q, acc_first_d;
  logic [COUNT_WIDTH-1:0] acc_count_q, acc_count_d;
  logic                   collision_q, collision_d;
  logic [4:0]             edge_mask_q, edge_mask_d;
  logic [2:0]             first_code_q, first_code_d;
  logic [COUNT_WIDTH-1:0] overlap_count_q, overlap_count_d;
  logic                   frame_valid_q, frame_valid_d;

  logic                   overlap;
  logic                   code_valid;
  logic [4:0]             pix_mask;
  logic [4:0]             base_mask;
  logic [2:0]             base_first;
  logic [COUNT_WIDTH-1:0] base_count;

  assign overlap    = bus.enable & bus.objDrawingRequest & bus.otherDrawingRequest;
  assign code_valid = (bus.objHitEdgeCode <= 3'd4);
  assign pix_mask   = code_valid ? (5'b00001 << bus.objHitEdgeCode) : 5'b00000;

  // Next-state, accumulator update and report generation.
  always_comb begin
    state_d         = state_q;
    acc_mask_d      = acc_mask_q;
    acc_first_d     = acc_first_q;
    acc_count_d     = acc_count_q;
    collision_d     = 1'b0;
    edge_mask_d     = edge_mask_q;
    first_code_d    = first_code_q;
    overlap_count_d = overlap_count_q;
    frame_valid_d   = frame_valid_q;

    // A SOF restarts the accumulators; a coincident overlap then lands on
    // the fresh frame rather than the one being reported.
    base_mask  = bus.startOfFrame ? 5'b00000 : acc_mask_q;
    base_first = bus.startOfFrame ? 3'd0 : acc_first_q;
    base_count = bus.startOfFrame ? '0 : acc_count_q;

    if (bus.startOfFrame) begin
      acc_mask_d  = base_mask;
      acc_first_d = base_first;
      acc_count_d = base_count;
    end

    if (overlap && (state_q == StCollect || bus.startOfFrame)) begin
      acc_mask_d = base_mask | pix_mask;
      // An empty mask means no recordable code has hit yet this frame.
      if (code_valid && base_mask == 5'b00000) acc_first_d = bus.objHitEdgeCode;
      if (base_count != {COUNT_WIDTH{1'b1}}) acc_count_d = base_count + COUNT_WIDTH'(1);
    end

    unique case (state_q)
      StWaitSof: begin
        if (bus.startOfFrame) state_d = StCollect;
      end
      StCollect: begin
        if (bus.startOfFrame) begin
          frame_valid_d = 1'b1;
          if (acc_count_q >= COUNT_WIDTH'(MIN_PIXELS)) begin
            collision_d     = 1'b1;
            edge_mask_d     = acc_mask_q;
            first_code_d    = acc_first_q;
            overlap_count_d = acc_count_q;
          end else begin
            edge_mask_d     = 5'b00000;
            first_code_d    = 3'd0;
            overlap_count_d = '0;
          end
        end
      end
      default: state_d = StWaitSof;
    endcase
  end

  // State, accumulator and report registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StWaitSof;
      acc_mask_q      <= 5'b00000;
      acc_first_q     <= 3'd0;
      acc_count_q     <= '0;
      collision_q     <= 1'b0;
      edge_mask_q     <= 5'b00000;
      first_code_q    <= 3'd0;
      overlap_count_q <= '0;
      frame_valid_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      acc_mask_q      <= acc_mask_d;
      acc_first_q     <= acc_first_d;
      acc_count_q     <= acc_count_d;
      collision_q     <= collision_d;
      edge_mask_q     <= edge_mask_d;
      first_code_q    <= first_code_d;
      overlap_count_q <= overlap_count_d;
      frame_valid_q   <= frame_valid_d;
    end
  end

  assign bus.collision     = collision_q;
  assign bus.edgeMask      = edge_mask_q;
  assign bus.firstEdgeCode = first_code_q;
  assign bus.overlapCount  = overlap_count_q;
  assign bus.frameValid    = frame_valid_q;

endmodule

// File: tb/tb_hit_edge_collector.sv
// Directed bench for hit_edge_collector. Three instances share one stimulus:
// a = defaults, b = MIN_PIXELS 4, c = COUNT_WIDTH 4.
module tb_hit_edge_collector;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       sof = 1'b0;
  logic       en = 1'b1;
  logic       obj = 1'b0;
  logic       oth = 1'b0;
  logic [2:0] code = 3'd0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  hit_edge_collector_if #(.COUNT_WIDTH(11)) if_a ();
  hit_edge_collector_if #(.COUNT_WIDTH(11)) if_b ();
  hit_edge_collector_if #(.COUNT_WIDTH(4))  if_c ();

  assign if_a.startOfFrame = sof;  assign if_a.enable = en;  assign if_a.objDrawingRequest = obj;
  assign if_a.objHitEdgeCode = code;  assign if_a.otherDrawingRequest = oth;
  assign if_b.startOfFrame = sof;  assign if_b.enable = en;  assign if_b.objDrawingRequest = obj;
  assign if_b.objHitEdgeCode = code;  assign if_b.otherDrawingRequest = oth;
  assign if_c.startOfFrame = sof;  assign if_c.enable = en;  assign if_c.objDrawingRequest = obj;
  assign if_c.objHitEdgeCode = code;  assign if_c.otherDrawingRequest = oth;

  hit_edge_collector #(.COUNT_WIDTH(11), .MIN_PIXELS(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  hit_edge_collector #(.COUNT_WIDTH(11), .MIN_PIXELS(4)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
  hit_edge_collector #(.COUNT_WIDTH(4),  .MIN_PIXELS(1)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, then sample 1 ns after the edge.
  task automatic step(input logic s, input logic o, input logic [2:0] c, input logic e);
    sof = s; obj = o; oth = o; code = c; en = e;
    @(posedge clk);
    #1;
    sof = 1'b0; obj = 1'b0; oth = 1'b0;
  endtask

  task automatic pix(input logic [2:0] c, input int n, input logic e);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, c, e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic check_a(input string tag, input int unsigned col, input int unsigned msk,
                         input int unsigned fst, input int unsigned cnt, input int unsigned fv);
    check({tag, ".a.collision"}, if_a.collision, col);
    check({tag, ".a.edgeMask"}, if_a.edgeMask, msk);
    check({tag, ".a.firstEdgeCode"}, if_a.firstEdgeCode, fst);
    check({tag, ".a.overlapCount"}, if_a.overlapCount, cnt);
    check({tag, ".a.frameValid"}, if_a.frameValid, fv);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    idle(2);
    check_a("reset", 0, 0, 0, 0, 0);
    check("reset.b.frameValid", if_b.frameValid, 0);
    reset = 1'b0;

    // Overlaps before the first SOF are ignored; first SOF gives no report
    pix(3'd3, 2, 1'b1);
    step(1'b1, 1'b0, 3'd0, 1'b1);
    check_a("first_sof", 0, 0, 0, 0, 0);
    idle(2);

    // Codes 3,3,1 then SOF; last overlap sits right before SOF
    pix(3'd3, 2, 1'b1);
    pix(3'd1, 1, 1'b1);
    step(1'b1, 1'b0, 3'd0, 1'b1);
    check_a("f331", 1, 5'b01010, 3, 3, 1);
    check("f331.b.collision", if_b.collision, 0);
    check("f331.b.edgeMask", if_b.edgeMask, 0);
    check("f331.b.overlapCount", if_b.overlapCount, 0);
    check("f331.b.frameValid", if_b.frameValid, 1);
    check("f331.c.overlapCount", if_c.overlapCount, 3);
    idle(1);
    check_a("f331_hold", 0, 5'b01010, 3, 3, 1);

    // Four overlaps: reaches MIN_PIXELS=4
    pix(3'd0, 1, 1'b1);
    pix(3'd1, 1, 1'b1);
    pix(3'd2, 1, 1'b1);
    pix(3'd4, 1, 1'b1);
    step(1'b1, 1'b0, 3'd0, 1'b1);
    check("f4.b.collision", if_b.collision, 1);
    check("f4.b.overlapCount", if_b.overlapCount, 4);
    check("f4.b.edgeMask", if_b.edgeMask, 5'b10111);
    check("f4.b.firstEdgeCode", if_b.firstEdgeCode, 0);
    check("f4.a.overlapCount", if_a.overlapCount, 4);

    // 20 overlaps at code 6: counted only, saturates at 15 on the narrow instance
    pix(3'd6, 20, 1'b1);
    step(1'b1, 1'b0, 3'd0, 1'b1);
    check("f20.c.collision", if_c.collision, 1);
    check("f20.c.overlapCount", if_c.overlapCount, 15);
    check("f20.c.edgeMask", if_c.edgeMask, 0);
    check("f20.c.firstEdgeCode", if_c.firstEdgeCode, 0);
    check_a("f20", 1, 0, 0, 20, 1);

    // Same stimulus with enable low
    pix(3'd6, 20, 1'b0);
    step(1'b1, 1'b0, 3'd0, 1'b1);
    check("f20off.c.collision", if_c.collision, 0);
    check("f20off.c.overlapCount", if_c.overlapCount, 0);
    check_a("f20off", 0, 0, 0, 0, 1);

    // Overlap coincident with SOF belongs to the new frame
    idle(3);
    step(1'b1, 1'b1, 3'd2, 1'b1);
    check_a("sofpix_old", 0, 0, 0, 0, 1);
    idle(3);
    step(1'b1, 1'b0, 3'd0, 1'b1);
    check_a("sofpix_new", 1, 5'b00100, 2, 1, 1);

    // Back-to-back SOFs, the first carrying an overlap at code 4
    step(1'b1, 1'b1, 3'd4, 1'b1);
    check_a("b2b_1", 0, 0, 0, 0, 1);
    step(1'b1, 1'b0, 3'd0, 1'b1);
    check_a("b2b_2", 1, 5'b10000, 4, 1, 1);
    idle(1);
    check("b2b_pulse_end", if_a.collision, 0);

    // Reset mid-frame after 5 overlaps: interrupted frame never reported
    pix(3'd1, 5, 1'b1);
    reset = 1'b1;
    idle(2);
    check_a("midreset", 0, 0, 0, 0, 0);
    reset = 1'b0;
    idle(2);
    step(1'b1, 1'b0, 3'd0, 1'b1);
    check_a("midreset_sof1", 0, 0, 0, 0, 0);
    idle(2);
    step(1'b1, 1'b0, 3'd0, 1'b1);
    check_a("midreset_sof2", 0, 0, 0, 0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
